// File: rtl/alu_wb_pkg.sv
// alu_wb_pkg: shared CPU definitions for the ALU write-back block.
// Holds the default tag-FIFO depth and register-index width, the layout of
// a write-back tag {reg, wr, wf}, and the condition-code bit positions.
package alu_wb_pkg;

    localparam int DEPTH_DEF = 4;   // outstanding ALU ops tracked
    localparam int RW_DEF    = 5;   // register-index width

    // Tag layout: {reg[RW-1:0], wr, wf}; the two control bits sit at the bottom.
    localparam int TAG_CTRL_W = 2;
    localparam int TAG_WR_BIT = 1;
    localparam int TAG_WF_BIT = 0;

    // Condition-code bit positions within a 4-bit flags word.
    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    function automatic int tag_width(input int rw);
        return rw + TAG_CTRL_W;
    endfunction

endpackage

// File: rtl/wb_tagfifo.sv
// wb_tagfifo: synchronous in-order tag FIFO with registered occupancy count.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_flush           empty the FIFO this cycle (overrides push/pop)
//   i_push, i_push_data  enqueue; caller only pushes when not full or popping
//   i_pop             dequeue head; caller only pops when not empty
//   o_head            current head entry (combinational read)
//   o_count           entries held, log2(DEPTH)+1 bits
//   o_full, o_empty   occupancy flags derived from o_count
module wb_tagfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 7
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (i_push) wr_ptr <= wr_ptr + AW'(1);
            if (i_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   o_count <= o_count + (AW+1)'(1);
                2'b01:   o_count <= o_count - (AW+1)'(1);
                default: o_count <= o_count;
            endcase
        end
    end

    // Storage carries no reset; entries are only read while counted valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush && !i_rst) mem[wr_ptr] <= i_push_data;
    end

    assign o_head  = mem[rd_ptr];
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign o_empty = (o_count == '0);

endmodule

// File: rtl/alu_wb.sv
// alu_wb: ALU result write-back sequencer.
// Tracks the destination of every op issued to the ALU in an in-order tag
// FIFO and, when the ALU reports a result, produces registered register-file
// and condition-code writes for the oldest outstanding op. A pipeline flush
// turns every tag still in flight into a "discard" credit so that results
// already in the ALU are swallowed without writing anything.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_issue, i_issue_reg/wr/wf    op issued to the ALU and its tag
//   i_clear                       pipeline flush
//   i_valid, i_c, i_f             ALU result strobe, data and flags {V,N,C,Z}
//   o_stall                       upstream must not issue (combinational)
//   o_wr_en/o_wr_reg/o_wr_data    register-file write port (registered)
//   o_flags_en/o_flags            condition-code write port (registered)
//   o_pending                     any tag outstanding, queued or discarded
//   o_err                         sticky protocol error
//
// Handshake: there is no ready on the result side. o_stall is the only
// back-pressure: upstream issues only while o_stall is low. An issue into a
// full FIFO without a same-cycle pop, or a result with nothing outstanding,
// is a protocol violation, is dropped, and sets o_err until reset.
module alu_wb
    import alu_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int RW    = RW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_issue,
    input  logic [RW-1:0] i_issue_reg,
    input  logic          i_issue_wr,
    input  logic          i_issue_wf,
    input  logic          i_clear,
    input  logic          i_valid,
    input  logic [31:0]   i_c,
    input  logic [3:0]    i_f,
    output logic          o_stall,
    output logic          o_wr_en,
    output logic [RW-1:0] o_wr_reg,
    output logic [31:0]   o_wr_data,
    output logic          o_flags_en,
    output logic [3:0]    o_flags,
    output logic          o_pending,
    output logic          o_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = tag_width(RW);

    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [TW-1:0] head;

    logic [CW-1:0] discard;
    logic [CW-1:0] disc_next;
    logic [CW:0]   disc_sum;
    logic [CW:0]   occupancy;

    logic disc_zero;
    logic pop_ok;
    logic disc_dec;
    logic push;
    logic issue_ovf;
    logic orphan;

    assign disc_zero = (discard == '0);
    // A result belongs to a queued tag only once all discard credits are used.
    assign pop_ok    = i_valid && disc_zero && !empty;
    assign disc_dec  = i_valid && !disc_zero;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the issue.
    assign push      = i_issue && !i_clear && (!full || pop_ok);
    assign issue_ovf = i_issue && !i_clear && full && !pop_ok;
    assign orphan    = i_valid && disc_zero && empty;

    wb_tagfifo #(
        .DEPTH (DEPTH),
        .W     (TW)
    ) u_tagfifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_clear),
        .i_push      (push),
        .i_push_data ({i_issue_reg, i_issue_wr, i_issue_wf}),
        .i_pop       (pop_ok),
        .o_head      (head),
        .o_count     (count),
        .o_full      (full),
        .o_empty     (empty)
    );

    // On a flush every tag left after this cycle's pop becomes a discard
    // credit; a result arriving in the same cycle still consumes one credit
    // or pops first. The sum saturates if upstream ignores o_stall.
    always_comb begin
        disc_sum = {1'b0, discard};
        if (disc_dec) disc_sum = disc_sum - (CW+1)'(1);
        if (i_clear)  disc_sum = disc_sum + {1'b0, count} - (CW+1)'(pop_ok);
        disc_next = disc_sum[CW] ? '1 : disc_sum[CW-1:0];
    end

    assign occupancy = {1'b0, count} + {1'b0, discard};
    assign o_stall   = (occupancy >= (CW+1)'(DEPTH));
    assign o_pending = !empty || !disc_zero;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            discard    <= '0;
            o_err      <= 1'b0;
            o_wr_en    <= 1'b0;
            o_flags_en <= 1'b0;
            o_wr_reg   <= '0;
            o_wr_data  <= '0;
            o_flags    <= '0;
        end else begin
            discard    <= disc_next;
            o_err      <= o_err || issue_ovf || orphan;
            o_wr_en    <= pop_ok && head[TAG_WR_BIT];
            o_flags_en <= pop_ok && head[TAG_WF_BIT];
            if (pop_ok) begin
                o_wr_reg  <= head[TW-1:TAG_CTRL_W];
                o_wr_data <= i_c;
                o_flags   <= {i_f[FLAG_V], i_f[FLAG_N], i_f[FLAG_C], i_f[FLAG_Z]};
            end
        end
    end

endmodule

// File: tb/tb_alu_wb.sv
// tb_alu_wb: self-checking bench for alu_wb, directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_alu_wb;
    localparam int DEPTH = 4;
    localparam int RW    = 5;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_issue;
    logic [RW-1:0] i_issue_reg;
    logic          i_issue_wr;
    logic          i_issue_wf;
    logic          i_clear;
    logic          i_valid;
    logic [31:0]   i_c;
    logic [3:0]    i_f;
    logic          o_stall;
    logic          o_wr_en;
    logic [RW-1:0] o_wr_reg;
    logic [31:0]   o_wr_data;
    logic          o_flags_en;
    logic [3:0]    o_flags;
    logic          o_pending;
    logic          o_err;

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    alu_wb #(.DEPTH(DEPTH), .RW(RW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_issue     (i_issue),
        .i_issue_reg (i_issue_reg),
        .i_issue_wr  (i_issue_wr),
        .i_issue_wf  (i_issue_wf),
        .i_clear     (i_clear),
        .i_valid     (i_valid),
        .i_c         (i_c),
        .i_f         (i_f),
        .o_stall     (o_stall),
        .o_wr_en     (o_wr_en),
        .o_wr_reg    (o_wr_reg),
        .o_wr_data   (o_wr_data),
        .o_flags_en  (o_flags_en),
        .o_flags     (o_flags),
        .o_pending   (o_pending),
        .o_err       (o_err)
    );

    // ---------------- reference model ----------------
    // Outstanding tags in issue order, packed {reg, wr, wf}.
    logic [RW+1:0] exp_q[$];
    int            m_disc;
    logic          m_err;
    logic          m_wr_en;
    logic          m_fe;
    logic [RW-1:0] m_reg;
    logic [31:0]   m_data;
    logic [3:0]    m_flags;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock of the behavioural model, evaluated on the inputs in force.
    task automatic model_step();
        logic [RW+1:0] t;
        if (i_rst) begin
            exp_q.delete();
            m_disc = 0; m_err = 0; m_wr_en = 0; m_fe = 0;
            m_reg = '0; m_data = '0; m_flags = '0;
            return;
        end
        m_wr_en = 0;
        m_fe    = 0;
        if (i_valid) begin
            if (m_disc > 0) begin
                m_disc--;
            end else if (exp_q.size() > 0) begin
                t       = exp_q.pop_front();
                m_wr_en = t[1];
                m_fe    = t[0];
                m_reg   = t[RW+1:2];
                m_data  = i_c;
                m_flags = i_f;
            end else begin
                m_err = 1;
            end
        end
        if (i_clear) begin
            m_disc += exp_q.size();
            exp_q.delete();
        end else if (i_issue) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({i_issue_reg, i_issue_wr, i_issue_wf});
            else m_err = 1;
        end
    endtask

    task automatic check_outs();
        chk("pending",  32'(o_pending),  32'(exp_q.size() > 0 || m_disc > 0));
        chk("err",      32'(o_err),      32'(m_err));
        chk("wr_en",    32'(o_wr_en),    32'(m_wr_en));
        chk("flags_en", 32'(o_flags_en), 32'(m_fe));
        chk("wr_reg",   32'(o_wr_reg),   32'(m_reg));
        chk("wr_data",  o_wr_data,       m_data);
        chk("flags",    32'(o_flags),    32'(m_flags));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        if (!i_rst) chk("stall", 32'(o_stall), 32'((exp_q.size() + m_disc) >= DEPTH));
        @(posedge i_clk);
        model_step();
        #1;
        check_outs();
    endtask

    task automatic drive(input logic iss, input logic [RW-1:0] rg, input logic wr,
                         input logic wf, input logic clr, input logic vld,
                         input logic [31:0] c, input logic [3:0] f);
        i_rst = 0; i_issue = iss; i_issue_reg = rg; i_issue_wr = wr; i_issue_wf = wf;
        i_clear = clr; i_valid = vld; i_c = c; i_f = f;
        cycle();
    endtask

    task automatic idle();
        drive(0, '0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        i_rst = 1; i_issue = 0; i_clear = 0; i_valid = 0;
        cycle();
        i_rst = 0;
    endtask

    task automatic issue(input logic [RW-1:0] rg);
        drive(1, rg, 1, 1, 0, 0, '0, '0);
    endtask

    task automatic result(input logic [31:0] c);
        drive(0, '0, 0, 0, 0, 1, c, 4'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        i_rst = 1; i_issue = 0; i_issue_reg = '0; i_issue_wr = 0; i_issue_wf = 0;
        i_clear = 0; i_valid = 0; i_c = '0; i_f = '0;
        repeat (2) begin
            @(posedge i_clk);
            model_step();
            #1;
        end
        check_outs();
        chk("rst_stall", 32'(o_stall), 32'(0));

        // single op, result two cycles after issue
        issue(5'd3);
        idle();
        result(32'h5);
        chk("r3_wr_en", 32'(o_wr_en), 32'(1));
        chk("r3_reg",   32'(o_wr_reg), 32'(3));
        chk("r3_data",  o_wr_data, 32'h5);
        chk("r3_fe",    32'(o_flags_en), 32'(1));
        idle();

        // fill, then overflow
        for (int i = 1; i <= 4; i++) issue(RW'(i));
        chk("full_stall", 32'(o_stall), 32'(1));
        issue(5'd5);
        chk("ovf_err", 32'(o_err), 32'(1));
        do_reset();

        // full with simultaneous issue and result
        for (int i = 1; i <= 4; i++) issue(RW'(i));
        drive(1, 5'd7, 1, 0, 0, 1, 32'h77, 4'h9);
        chk("swap_reg", 32'(o_wr_reg), 32'(1));
        chk("swap_err", 32'(o_err), 32'(0));
        chk("swap_stall", 32'(o_stall), 32'(1));
        for (int i = 0; i < 4; i++) result(32'h100 + i);
        idle();

        // flush with two in flight, then a new op
        issue(5'd1);
        issue(5'd2);
        drive(0, '0, 0, 0, 1, 0, '0, '0);
        issue(5'd5);
        result(32'hA);
        chk("disc_a", 32'(o_wr_en), 32'(0));
        result(32'hB);
        chk("disc_b", 32'(o_wr_en), 32'(0));
        result(32'hC);
        chk("flush_reg",  32'(o_wr_reg), 32'(5));
        chk("flush_data", o_wr_data, 32'hC);
        idle();

        // result coincident with flush pops first, rest discarded
        issue(5'd9); issue(5'd10); issue(5'd11);
        drive(0, '0, 0, 0, 1, 1, 32'hD0, 4'h3);
        chk("clrv_reg", 32'(o_wr_reg), 32'(9));
        result(32'hE0); result(32'hE1);
        idle();

        // orphan result, sticky until reset
        result(32'hF00D);
        chk("orphan_wr", 32'(o_wr_en), 32'(0));
        repeat (3) idle();
        chk("orphan_sticky", 32'(o_err), 32'(1));
        do_reset();
        chk("orphan_clr", 32'(o_err), 32'(0));

        // reset with two tags queued
        issue(5'd12); issue(5'd13);
        do_reset();
        chk("rst_q_pending", 32'(o_pending), 32'(0));
        chk("rst_q_stall",   32'(o_stall), 32'(0));

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic iss;
            int   occ;
            occ = exp_q.size() + m_disc;
            if (occ < DEPTH)
                iss = ($urandom_range(1, 0) == 1);
            else if (m_disc == 0)
                iss = ($urandom_range(7, 0) == 0);
            else
                iss = 0;
            if ($urandom_range(199, 0) == 0) begin
                do_reset();
            end else begin
                drive(iss, RW'($urandom_range(31, 0)), 1'($urandom_range(1, 0)),
                      1'($urandom_range(1, 0)), ($urandom_range(19, 0) == 0),
                      ($urandom_range(2, 0) == 0), $urandom(), 4'($urandom_range(15, 0)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
